// File: rtl/spike_event_logger_pkg.sv
// Shared definitions for the spike event logger: default widths, FIFO operation
// encoding and the saturating counter helper.
package spike_event_logger_pkg;

   localparam int STATE_W_DEF = 8;
   localparam int TS_W_DEF    = 16;
   localparam logic [7:0] SAT_MAX = 8'hFF;

   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_POP  = 2'b01,
      OP_PUSH = 2'b10,
      OP_BOTH = 2'b11
   } fifo_op_e;

   // Event words are packed {wrap, ts, state}, MSB first.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      logic [7:0] r;
      if (v == SAT_MAX) begin
         r = v;
      end else begin
         r = v + 8'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/spike_event_logger_sync_fifo.sv
// Show-ahead synchronous FIFO; head word is read straight from storage and the
// occupancy counter separates full from empty.
module spike_event_logger_sync_fifo
   import spike_event_logger_pkg::*;
#(
   parameter int WIDTH = 25,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;
   fifo_op_e         op;

   assign empty   = (count == {(AW+1){1'b0}});
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign op      = fifo_op_e'({do_push, do_pop});
   assign dout    = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= {AW{1'b0}};
         rd_ptr <= {AW{1'b0}};
         count  <= {(AW+1){1'b0}};
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case (op)
            OP_PUSH: count <= count + (AW+1)'(1);
            OP_POP:  count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage array; contents need no reset because the counter gates visibility.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/spike_event_logger.sv
// Captures lif spikes as timestamped events into a FIFO for a valid/ready reader
// and reports the number of spikes seen per rate window.
module spike_event_logger
   import spike_event_logger_pkg::*;
#(
   parameter int TS_W     = TS_W_DEF,
   parameter int STATE_W  = STATE_W_DEF,
   parameter int DEPTH    = 8,
   parameter int RATE_WIN = 256
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable,
   input  logic                     spike_in,
   input  logic [STATE_W-1:0]       state_in,
   input  logic                     ev_ready,
   output logic                     ev_valid,
   output logic [TS_W-1:0]          ev_ts,
   output logic [STATE_W-1:0]       ev_state,
   output logic                     ev_wrap,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic [7:0]               dropped,
   output logic [7:0]               rate,
   output logic                     rate_valid
);

   localparam int EV_W  = TS_W + STATE_W + 1;
   localparam int WIN_W = $clog2(RATE_WIN);
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(RATE_WIN - 1);

   logic [TS_W-1:0]  ts;
   logic             wrap_pend;
   logic [WIN_W-1:0] win_cnt;
   logic [7:0]       spk_cnt;
   logic             push_req;
   logic             pop;
   logic             push;
   logic             wrap_now;
   logic             full;
   logic             empty;
   logic [EV_W-1:0]  din;
   logic [EV_W-1:0]  dout;

   assign push_req = enable & spike_in;
   assign ev_valid = ~empty;
   assign pop      = ev_valid & ev_ready;
   assign push     = push_req & (~full | pop);
   assign wrap_now = enable & (ts == {TS_W{1'b1}});
   assign din      = {wrap_pend | wrap_now, ts, state_in};

   spike_event_logger_sync_fifo #(
      .WIDTH (EV_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (din),
      .dout  (dout),
      .full  (full),
      .empty (empty),
      .count (fifo_count)
   );

   // Head event is forced to zero while the FIFO is empty.
   always_comb begin
      {ev_wrap, ev_ts, ev_state} = {EV_W{1'b0}};
      if (ev_valid) begin
         {ev_wrap, ev_ts, ev_state} = dout;
      end else begin
         {ev_wrap, ev_ts, ev_state} = {EV_W{1'b0}};
      end
   end

   // Timestamp counter and the wrap flag carried to the next accepted event.
   always_ff @(posedge clk) begin
      if (rst) begin
         ts        <= {TS_W{1'b0}};
         wrap_pend <= 1'b0;
      end else begin
         if (enable) ts <= ts + TS_W'(1);
         if (push) begin
            wrap_pend <= 1'b0;
         end else if (wrap_now) begin
            wrap_pend <= 1'b1;
         end else begin
            wrap_pend <= wrap_pend;
         end
      end
   end

   // Saturating count of events lost to a full FIFO.
   always_ff @(posedge clk) begin
      if (rst) begin
         dropped <= 8'd0;
      end else if (push_req && !push) begin
         dropped <= sat_inc8(dropped);
      end else begin
         dropped <= dropped;
      end
   end

   // Windowed spike rate; dropped spikes still count toward the rate.
   always_ff @(posedge clk) begin
      if (rst) begin
         win_cnt    <= {WIN_W{1'b0}};
         spk_cnt    <= 8'd0;
         rate       <= 8'd0;
         rate_valid <= 1'b0;
      end else begin
         rate_valid <= 1'b0;
         if (enable) begin
            if (win_cnt == WIN_LAST) begin
               rate       <= push_req ? sat_inc8(spk_cnt) : spk_cnt;
               rate_valid <= 1'b1;
               spk_cnt    <= 8'd0;
               win_cnt    <= {WIN_W{1'b0}};
            end else begin
               win_cnt <= win_cnt + WIN_W'(1);
               if (push_req) spk_cnt <= sat_inc8(spk_cnt);
            end
         end
      end
   end

endmodule

// File: tb/tb_spike_event_logger.sv
// Bench for spike_event_logger: two instances (TS_W=4/RATE_WIN=16 and
// TS_W=16/RATE_WIN=512) share stimulus and are compared each cycle with a queue model.
module tb_spike_event_logger;

   logic       clk;
   logic       rst;
   logic       enable;
   logic       spike_in;
   logic [7:0] state_in;
   logic       ev_ready;

   logic       a_ev_valid, b_ev_valid;
   logic [3:0] a_ev_ts;
   logic [15:0] b_ev_ts;
   logic [7:0] a_ev_state, b_ev_state;
   logic       a_ev_wrap, b_ev_wrap;
   logic [3:0] a_fifo_count, b_fifo_count;
   logic [7:0] a_dropped, b_dropped, a_rate, b_rate;
   logic       a_rate_valid, b_rate_valid;

   int checks = 0;
   int errors = 0;

   spike_event_logger #(.TS_W(4), .STATE_W(8), .DEPTH(8), .RATE_WIN(16)) u_a (
      .clk(clk), .rst(rst), .enable(enable), .spike_in(spike_in), .state_in(state_in),
      .ev_ready(ev_ready), .ev_valid(a_ev_valid), .ev_ts(a_ev_ts), .ev_state(a_ev_state),
      .ev_wrap(a_ev_wrap), .fifo_count(a_fifo_count), .dropped(a_dropped), .rate(a_rate),
      .rate_valid(a_rate_valid));

   spike_event_logger #(.TS_W(16), .STATE_W(8), .DEPTH(8), .RATE_WIN(512)) u_b (
      .clk(clk), .rst(rst), .enable(enable), .spike_in(spike_in), .state_in(state_in),
      .ev_ready(ev_ready), .ev_valid(b_ev_valid), .ev_ts(b_ev_ts), .ev_state(b_ev_state),
      .ev_wrap(b_ev_wrap), .fifo_count(b_fifo_count), .dropped(b_dropped), .rate(b_rate),
      .rate_valid(b_rate_valid));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: events are numbered by push order; head = oldest unread number.
   int m_ts [2];
   int m_pend [2];
   int m_drop [2];
   int m_rate [2];
   int m_rv [2];
   int m_win [2];
   int m_spk [2];
   int m_wr [2];
   int m_rd [2];
   int q_ts [0:1][0:1023];
   int q_st [0:1][0:1023];
   int q_wp [0:1][0:1023];
   bit m_live = 1'b0;

   function automatic int ts_mod(input int k);
      return (k == 0) ? 16 : 65536;
   endfunction

   function automatic int win_len(input int k);
      return (k == 0) ? 16 : 512;
   endfunction

   function automatic int sat255(input int v);
      return (v > 255) ? 255 : v;
   endfunction

   task automatic model_step(input int k);
      int  cnt;
      bit  preq, popv, wrapn;
      cnt = m_wr[k] - m_rd[k];
      if (rst) begin
         m_ts[k] = 0; m_pend[k] = 0; m_drop[k] = 0; m_rate[k] = 0; m_rv[k] = 0;
         m_win[k] = 0; m_spk[k] = 0; m_wr[k] = 0; m_rd[k] = 0;
         return;
      end
      preq  = enable && spike_in;
      popv  = (cnt != 0) && ev_ready;
      wrapn = enable && (m_ts[k] == ts_mod(k) - 1);
      if (preq && (cnt < 8 || popv)) begin
         q_ts[k][m_wr[k] % 1024] = m_ts[k];
         q_st[k][m_wr[k] % 1024] = int'(state_in);
         q_wp[k][m_wr[k] % 1024] = (m_pend[k] != 0 || wrapn) ? 1 : 0;
         m_wr[k]   = m_wr[k] + 1;
         m_pend[k] = 0;
      end else begin
         if (preq) m_drop[k] = sat255(m_drop[k] + 1);
         if (wrapn) m_pend[k] = 1;
      end
      if (popv) m_rd[k] = m_rd[k] + 1;
      m_rv[k] = 0;
      if (enable) begin
         m_ts[k] = (m_ts[k] + 1) % ts_mod(k);
         if (m_win[k] == win_len(k) - 1) begin
            m_rate[k] = sat255(m_spk[k] + int'(preq));
            m_rv[k]   = 1;
            m_spk[k]  = 0;
            m_win[k]  = 0;
         end else begin
            m_win[k] = m_win[k] + 1;
            m_spk[k] = sat255(m_spk[k] + int'(preq));
         end
      end
   endtask

   function automatic int exp_cnt(input int k);
      return m_wr[k] - m_rd[k];
   endfunction

   function automatic int exp_head(input int k, input int field);
      int idx;
      idx = m_rd[k] % 1024;
      if (exp_cnt(k) == 0) return 0;
      case (field)
         0:       return q_ts[k][idx];
         1:       return q_st[k][idx];
         default: return q_wp[k][idx];
      endcase
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (m_live) begin
         chk("a.ev_valid", int'(a_ev_valid), int'(exp_cnt(0) != 0));
         chk("a.ev_ts", int'(a_ev_ts), exp_head(0, 0));
         chk("a.ev_state", int'(a_ev_state), exp_head(0, 1));
         chk("a.ev_wrap", int'(a_ev_wrap), exp_head(0, 2));
         chk("a.fifo_count", int'(a_fifo_count), exp_cnt(0));
         chk("a.dropped", int'(a_dropped), m_drop[0]);
         chk("a.rate", int'(a_rate), m_rate[0]);
         chk("a.rate_valid", int'(a_rate_valid), m_rv[0]);
         chk("b.ev_valid", int'(b_ev_valid), int'(exp_cnt(1) != 0));
         chk("b.ev_ts", int'(b_ev_ts), exp_head(1, 0));
         chk("b.ev_state", int'(b_ev_state), exp_head(1, 1));
         chk("b.ev_wrap", int'(b_ev_wrap), exp_head(1, 2));
         chk("b.fifo_count", int'(b_fifo_count), exp_cnt(1));
         chk("b.dropped", int'(b_dropped), m_drop[1]);
         chk("b.rate", int'(b_rate), m_rate[1]);
         chk("b.rate_valid", int'(b_rate_valid), m_rv[1]);
      end
   end

   task automatic step(input bit r, input bit en, input bit sp, input int st, input bit rd);
      rst      = r;
      enable   = en;
      spike_in = sp;
      state_in = st[7:0];
      ev_ready = rd;
      @(posedge clk);
      model_step(0);
      model_step(1);
      m_live = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int drained_ts [8];
      int asc;
      int s;
      rst = 1'b1; enable = 1'b0; spike_in = 1'b0; state_in = 8'd0; ev_ready = 1'b0;

      // Reset, then two events at ts=5 and ts=9 read immediately
      step(1'b1, 1'b0, 1'b0, 0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 0, 1'b0);
      chk("t1.reset_valid", int'(b_ev_valid), 0);
      chk("t1.reset_count", int'(b_fifo_count), 0);
      chk("t1.reset_rate", int'(a_rate), 0);
      for (int i = 0; i < 12; i++) begin
         step(1'b0, 1'b1, (i == 5 || i == 9), (i == 5) ? 8'hA5 : 8'h3C, 1'b1);
         if (i == 5) begin
            chk("t1.ev5_valid", int'(b_ev_valid), 1);
            chk("t1.ev5_ts", int'(b_ev_ts), 5);
            chk("t1.ev5_state", int'(b_ev_state), 8'hA5);
            chk("t1.ev5_wrap", int'(b_ev_wrap), 0);
         end
         if (i == 9) begin
            chk("t1.ev9_ts", int'(a_ev_ts), 9);
            chk("t1.ev9_state", int'(a_ev_state), 8'h3C);
         end
      end
      chk("t1.count_end", int'(b_fifo_count), 0);
      chk("t1.dropped", int'(b_dropped), 0);

      // Ten back-to-back spikes with reader stalled: eight kept, two dropped
      for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, 8'h10 + i, 1'b0);
      chk("t2.count_full", int'(b_fifo_count), 8);
      chk("t2.dropped", int'(b_dropped), 2);

      // Push into a full FIFO while popping is accepted
      step(1'b0, 1'b1, 1'b1, 8'h77, 1'b1);
      chk("t3.count", int'(b_fifo_count), 8);
      chk("t3.dropped", int'(b_dropped), 2);

      for (int i = 0; i < 8; i++) begin
         drained_ts[i] = int'(b_ev_ts);
         step(1'b0, 1'b0, 1'b0, 0, 1'b1);
      end
      asc = 1;
      for (int i = 1; i < 8; i++) if (drained_ts[i] <= drained_ts[i-1]) asc = 0;
      chk("t2.ascending", asc, 1);
      chk("t2.first_ts", drained_ts[0], 13);
      chk("t3.last_ts", drained_ts[7], 22);
      chk("t2.empty_after", int'(b_fifo_count), 0);

      // Wrap flag on the 4-bit timestamp instance
      for (int g = 0; g < 40 && m_ts[0] != 14; g++) step(1'b0, 1'b1, 1'b0, 0, 1'b1);
      if (m_ts[0] != 14) chk("t4.align_timeout", m_ts[0], 14);
      step(1'b0, 1'b1, 1'b1, 8'h41, 1'b1);
      chk("t4.ts14", int'(a_ev_ts), 14);
      chk("t4.ts14_wrap", int'(a_ev_wrap), 0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 0, 1'b1);
      step(1'b0, 1'b1, 1'b1, 8'h42, 1'b1);
      chk("t4.ts2", int'(a_ev_ts), 2);
      chk("t4.ts2_wrap", int'(a_ev_wrap), 1);
      step(1'b0, 1'b1, 1'b1, 8'h43, 1'b1);
      chk("t4.ts3", int'(a_ev_ts), 3);
      chk("t4.ts3_wrap", int'(a_ev_wrap), 0);

      // Rate window of 16 with five spikes including the last window cycle
      step(1'b1, 1'b0, 1'b0, 0, 1'b0);
      for (int i = 0; i < 16; i++)
         step(1'b0, 1'b1, (i == 1 || i == 4 || i == 7 || i == 10 || i == 15), i, 1'b1);
      chk("t5.rate", int'(a_rate), 5);
      chk("t5.rate_valid", int'(a_rate_valid), 1);
      step(1'b0, 1'b1, 1'b0, 0, 1'b1);
      chk("t5.rate_valid_drop", int'(a_rate_valid), 0);
      chk("t5.rate_hold", int'(a_rate), 5);

      // 300 spikes in a 512 window saturate the rate
      step(1'b1, 1'b0, 1'b0, 0, 1'b0);
      for (int i = 0; i < 512; i++) step(1'b0, 1'b1, (i < 300), i, 1'b1);
      chk("t5.rate_sat", int'(b_rate), 255);
      chk("t5.rate_sat_valid", int'(b_rate_valid), 1);

      // Reset with queued events, then spikes while disabled
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 8'h50 + i, 1'b0);
      chk("t6.queued", int'(b_fifo_count), 4);
      step(1'b1, 1'b1, 1'b0, 0, 1'b0);
      chk("t6.valid", int'(b_ev_valid), 0);
      chk("t6.count", int'(b_fifo_count), 0);
      chk("t6.ev_ts", int'(b_ev_ts), 0);
      chk("t6.rate", int'(b_rate), 0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 8'h66, 1'b1);
      chk("t6.no_push", int'(b_fifo_count), 0);
      step(1'b0, 1'b1, 1'b1, 8'h99, 1'b0);
      chk("t6.ts_frozen_b", int'(b_ev_ts), 0);
      chk("t6.ts_frozen_a", int'(a_ev_ts), 0);
      chk("t6.state", int'(b_ev_state), 8'h99);

      // Randomized traffic against the model
      for (int i = 0; i < 1500; i++) begin
         s = int'($urandom_range(0, 255));
         step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 8),
              ($urandom_range(0, 1) == 1), s, ($urandom_range(0, 2) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
